// File: rtl/data_mem_arbiter_if.sv
// Requester, response and memory-strobe bundle for data_mem_arbiter.
// master = requesters plus memory model side, slave = the arbiter.
interface data_mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        rw0;
    logic        rw1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  size0;
    logic [1:0]  size1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_size;
    logic [31:0] mem_data_out;

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, size0, size1,
        input  ack0, ack1, rsp_data, rsp_err, busy,
        input  mem_enable, mem_rw, mem_address, mem_data_in, mem_size,
        output mem_data_out
    );

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, size0, size1,
        output ack0, ack1, rsp_data, rsp_err, busy,
        output mem_enable, mem_rw, mem_address, mem_data_in, mem_size,
        input  mem_data_out
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter and access sequencer for the byte/half/word data memory.
// Define RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int MEM_BYTES     = 256,
    parameter int ACCESS_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] LAST_CNT  = 4'(ACCESS_CYCLES - 1);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        gnt_r;
    logic        last_grant_r;
    logic        ack0_r;
    logic        ack1_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;
    logic        busy_r;
    logic        mem_enable_r;
    logic        mem_rw_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_data_in_r;
    logic [1:0]  mem_size_r;

    logic        any_req_s;
    logic        win_s;
    logic        sel_rw_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [1:0]  sel_size_s;
    logic [32:0] nbytes_s;
    logic [32:0] last_byte_s;
    logic        fault_s;

    function automatic logic [31:0] mask_to_size(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] m;
        case (s)
            2'b00:   m = {24'h000000, d[7:0]};
            2'b01:   m = {16'h0000, d[15:0]};
            default: m = d;
        endcase
        return m;
    endfunction

    assign any_req_s = bus.req0 | bus.req1;

    // Pick the winner among pending requesters
    always_comb begin
        if (bus.req0 && bus.req1) begin
`ifdef RR_ARB_EN
            win_s = ~last_grant_r;
`else
            win_s = 1'b0;
`endif
        end else begin
            win_s = bus.req1;
        end
    end

`ifndef RR_ARB_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant_r;
`endif

    // Route the winning requester's fields
    always_comb begin
        if (win_s) begin
            sel_rw_s    = bus.rw1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
            sel_size_s  = bus.size1;
        end else begin
            sel_rw_s    = bus.rw0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
            sel_size_s  = bus.size0;
        end
    end

    // Fault check: illegal size, misalignment, or last byte beyond memory (33-bit, no wrap)
    always_comb begin
        case (sel_size_s)
            2'b00:   nbytes_s = 33'd1;
            2'b01:   nbytes_s = 33'd2;
            default: nbytes_s = 33'd4;
        endcase
        last_byte_s = {1'b0, sel_addr_s} + nbytes_s - 33'd1;
        fault_s = (sel_size_s == 2'b11)
               || ((sel_size_s == 2'b01) && (sel_addr_s[0] != 1'b0))
               || ((sel_size_s == 2'b10) && (sel_addr_s[1:0] != 2'b00))
               || (last_byte_s >= 33'(MEM_BYTES));
    end

    // Sequencer: grant, hold strobes for the access window, then one-cycle response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            gnt_r         <= 1'b0;
            last_grant_r  <= 1'b1;
            ack0_r        <= 1'b0;
            ack1_r        <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_err_r     <= 1'b0;
            busy_r        <= 1'b0;
            mem_enable_r  <= 1'b0;
            mem_rw_r      <= 1'b0;
            mem_address_r <= 32'd0;
            mem_data_in_r <= 32'd0;
            mem_size_r    <= 2'b00;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt_r        <= win_s;
                        last_grant_r <= win_s;
                        busy_r       <= 1'b1;
                        if (fault_s) begin
                            state_r    <= ST_RESP;
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= 32'd0;
                            ack0_r     <= ~win_s;
                            ack1_r     <= win_s;
                        end else begin
                            // mem_* registers double as the request latch
                            state_r       <= ST_ACCESS;
                            cnt_r         <= 4'd0;
                            mem_enable_r  <= 1'b1;
                            mem_rw_r      <= sel_rw_s;
                            mem_address_r <= sel_addr_s;
                            mem_data_in_r <= sel_wdata_s;
                            mem_size_r    <= sel_size_s;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r      <= ST_RESP;
                        mem_enable_r <= 1'b0;
                        rsp_err_r    <= 1'b0;
                        rsp_data_r   <= mem_rw_r ? 32'd0 : mask_to_size(bus.mem_data_out, mem_size_r);
                        ack0_r       <= ~gnt_r;
                        ack1_r       <= gnt_r;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    mem_enable_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0        = ack0_r;
    assign bus.ack1        = ack1_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.busy        = busy_r;
    assign bus.mem_enable  = mem_enable_r;
    assign bus.mem_rw      = mem_rw_r;
    assign bus.mem_address = mem_address_r;
    assign bus.mem_data_in = mem_data_in_r;
    assign bus.mem_size    = mem_size_r;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: big-endian byte memory model plus a reference model of
// memory contents, fault rules and arbitration; directed plan steps followed by random traffic.
module tb_data_mem_arbiter;
    localparam int AC  = 4;
    localparam int MEM = 256;

    logic clk = 1'b0;
    logic reset;
    data_mem_arbiter_if bus();

    data_mem_arbiter #(.MEM_BYTES(MEM), .ACCESS_CYCLES(AC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory attached to the strobes; upper bits of sub-word reads carry junk
    logic [7:0]  mem [MEM] = '{default: 8'h00};
    logic [7:0]  ma0, ma1, ma2, ma3;
    logic [31:0] rd_s;
    assign ma0 = bus.mem_address[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;

    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_rw) begin
            case (bus.mem_size)
                2'b00: mem[ma0] <= bus.mem_data_in[7:0];
                2'b01: begin
                    mem[ma0] <= bus.mem_data_in[15:8];
                    mem[ma1] <= bus.mem_data_in[7:0];
                end
                default: begin
                    mem[ma0] <= bus.mem_data_in[31:24];
                    mem[ma1] <= bus.mem_data_in[23:16];
                    mem[ma2] <= bus.mem_data_in[15:8];
                    mem[ma3] <= bus.mem_data_in[7:0];
                end
            endcase
        end
    end

    always_comb begin
        case (bus.mem_size)
            2'b00:   rd_s = {24'hC3C3C3, mem[ma0]};
            2'b01:   rd_s = {16'hC3C3, mem[ma0], mem[ma1]};
            default: rd_s = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};
        endcase
    end
    assign bus.mem_data_out = rd_s;

    // Reference model state
    logic [7:0]  ref_mem [MEM] = '{default: 8'h00};
    int          ref_last = 1;
    logic        f_rw    [2];
    logic [31:0] f_addr  [2];
    logic [31:0] f_wdata [2];
    logic [1:0]  f_size  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] a, input logic [1:0] s);
        longint unsigned nb;
        longint unsigned ua;
        if (s == 2'b11) return 1'b1;
        nb = 64'd1 << s;
        ua = {32'd0, a};
        if ((ua % nb) != 64'd0) return 1'b1;
        return (ua + nb) > 64'(MEM);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < (1 << s); i++) v = {v[23:0], ref_mem[int'(a[7:0]) + i]};
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
        int nb;
        nb = 1 << s;
        for (int i = 0; i < nb; i++) ref_mem[int'(a[7:0]) + i] = 8'(w >> (8 * (nb - 1 - i)));
    endtask

    function automatic int pick(input bit p0, input bit p1);
        if (p0 && p1) begin
`ifdef RR_ARB_EN
            return (ref_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return p1 ? 1 : 0;
    endfunction

    task automatic drive(input int p, input logic rq, input logic rw, input logic [31:0] a,
                         input logic [31:0] w, input logic [1:0] s);
        if (p == 0) begin
            bus.req0 = rq; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = w; bus.size0 = s;
        end else begin
            bus.req1 = rq; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = w; bus.size1 = s;
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) bus.req0 = v;
        else bus.req1 = v;
    endtask

    task automatic setf(input int p, input logic rw, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] s);
        f_rw[p] = rw; f_addr[p] = a; f_wdata[p] = w; f_size[p] = s;
    endtask

    task automatic rand_fields(input int p);
        logic [1:0]  s;
        logic [31:0] a;
        s = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(0, 255));
            1:       a = 32'($urandom_range(248, 255));
            2:       a = $urandom;
            default: a = 32'($urandom_range(0, 255)) & ~32'(3);
        endcase
        setf(p, 1'($urandom_range(0, 1)), a, $urandom, s);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {bus.ack0, bus.ack1, bus.rsp_err, bus.busy, bus.mem_enable,
                            bus.mem_rw, bus.mem_size, bus.rsp_data}, 64'd0);
        chk({tag, "_bus"}, {bus.mem_address, bus.mem_data_in}, 64'd0);
    endtask

    // Present requests, then for each grant check latency, port, data, error and strobes
    task automatic run(input bit p0, input bit p1, input bit hold, input int n);
        bit          pend [2];
        int          win, lat, en, exp_lat, samp;
        bit          got, exp_err;
        logic [31:0] exp_data;
        exp_data = 32'd0;
        pend[0] = p0;
        pend[1] = p1;
        if (p0) drive(0, 1'b1, f_rw[0], f_addr[0], f_wdata[0], f_size[0]);
        if (p1) drive(1, 1'b1, f_rw[1], f_addr[1], f_wdata[1], f_size[1]);
        for (int g = 0; g < n; g++) begin
            win      = pick(pend[0], pend[1]);
            exp_err  = ref_fault(f_addr[win], f_size[win]);
            exp_data = (exp_err || f_rw[win]) ? 32'd0 : ref_read(f_addr[win], f_size[win]);
            samp     = (g > 0) ? 2 : 1;
            exp_lat  = (exp_err ? 1 : AC + 1) + samp - 1;
            lat = 0; en = 0; got = 1'b0;
            while (!got && lat < 64) begin
                @(negedge clk);
                lat++;
                if (!hold && lat == samp)
                    drive(win, 1'b1, ~f_rw[win], $urandom, $urandom, 2'($urandom_range(0, 3)));
                if (bus.mem_enable) begin
                    en++;
                    chk("mem_address", bus.mem_address, f_addr[win]);
                    chk("mem_rw", bus.mem_rw, f_rw[win]);
                    chk("mem_size", bus.mem_size, f_size[win]);
                    if (f_rw[win]) chk("mem_data_in", bus.mem_data_in, f_wdata[win]);
                end
                if (bus.ack0 || bus.ack1) got = 1'b1;
            end
            chk("ack_seen", got, 1'b1);
            chk("latency", lat, exp_lat);
            chk("ack_port", {bus.ack1, bus.ack0}, (win == 1) ? 2'b10 : 2'b01);
            chk("busy_resp", bus.busy, 1'b1);
            chk("rsp_err", bus.rsp_err, exp_err);
            chk("rsp_data", bus.rsp_data, exp_data);
            chk("enable_cycles", en, exp_err ? 0 : AC);
            if (!exp_err && f_rw[win]) ref_write(f_addr[win], f_size[win], f_wdata[win]);
            ref_last = win;
            if (!hold) begin
                pend[win] = 1'b0;
                set_req(win, 1'b0);
            end
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        @(negedge clk);
        chk("ack_pulse", {bus.ack1, bus.ack0}, 2'b00);
        chk("idle_busy", bus.busy, 1'b0);
        chk("rsp_hold", bus.rsp_data, exp_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] flt_addr [4];
        logic [1:0]  flt_size [4];
        logic        acc;
        int          mism;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle_no_req");

        setf(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10); run(1, 0, 0, 1);
        chk("plan_write_rsp", bus.rsp_data, 32'h0);
        setf(0, 1'b0, 32'h10, 32'h0, 2'b10); run(1, 0, 0, 1);
        chk("plan_word_read", bus.rsp_data, 32'hDEADBEEF);
        setf(0, 1'b0, 32'h11, 32'h0, 2'b00); run(1, 0, 0, 1);
        chk("plan_byte_read", bus.rsp_data, 32'h000000AD);
        setf(0, 1'b0, 32'h12, 32'h0, 2'b01); run(1, 0, 0, 1);
        chk("plan_half_read", bus.rsp_data, 32'h0000BEEF);

        flt_addr = '{32'h13, 32'h0E, 32'hFE, 32'h20};
        flt_size = '{2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            setf(0, 1'b1, flt_addr[i], 32'hFFFF_FFFF, flt_size[i]);
            run(1, 0, 0, 1);
            chk("plan_fault_err", bus.rsp_err, 1'b1);
        end

        setf(1, 1'b1, 32'hFF, 32'h0000005A, 2'b00); run(0, 1, 0, 1);
        chk("plan_p1_write_err", bus.rsp_err, 1'b0);
        setf(0, 1'b0, 32'hFF, 32'h0, 2'b00); run(1, 0, 0, 1);
        chk("plan_ff_read", bus.rsp_data, 32'h0000005A);

        // Reset in the second access cycle; the write re-stores the current word
        drive(0, 1'b1, 1'b1, 32'h40, ref_read(32'h40, 2'b10), 2'b10);
        repeat (2) @(negedge clk);
        chk("mid_enable", bus.mem_enable, 1'b1);
        reset = 1'b1;
        set_req(0, 1'b0);
        @(negedge clk);
        check_zero("reset_mid");
        reset = 1'b0;
        ref_last = 1;
        acc = 1'b0;
        repeat (AC + 3) begin
            @(negedge clk);
            acc = acc | bus.ack0 | bus.ack1 | bus.busy;
        end
        chk("no_ack_after_reset", acc, 1'b0);

        // Held contention: port 1 starves under fixed priority, alternates under round-robin
        setf(0, 1'b0, 32'h10, 32'h0, 2'b10);
        setf(1, 1'b0, 32'hFF, 32'h0, 2'b00);
        run(1, 1, 1, 4);
`ifdef RR_ARB_EN
        chk("hold_last_grant", bus.rsp_data, 32'h0000005A);
`else
        chk("hold_last_grant", bus.rsp_data, 32'hDEADBEEF);
`endif
        run(1, 1, 0, 2);

        for (int it = 0; it < 60; it++) begin
            rand_fields(0);
            rand_fields(1);
            case ($urandom_range(0, 2))
                0:       run(1, 0, 0, 1);
                1:       run(0, 1, 0, 1);
                default: run(1, 1, 0, 2);
            endcase
        end

        mism = 0;
        for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final_mismatch_bytes", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the 256-byte data memory (byte/half/word, Enable/ReadWrite strobe interface).
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port.
- Grants one access at a time, drives the memory strobes for a fixed access window and captures read data.
- Returns a one-cycle ack with data or an access-fault flag.

Parameters:
- MEM_BYTES, 256, memory size in bytes; accesses reaching at or beyond this address fault.
- ACCESS_CYCLES, 1, cycles mem_enable is held high per access (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  access request, level; held until matching ack.
- rw0, rw1  input  1 each  1 = write, 0 = read (memory ReadWrite encoding).
- addr0, addr1  input  32 each  byte address.
- wdata0, wdata1  input  32 each  write data, right-justified.
- size0, size1  input  2 each  00 byte, 01 half, 10 word, 11 illegal.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rsp_data  output  32  read data; valid while ack0 or ack1 is high.
- rsp_err  output  1  fault flag; valid while ack0 or ack1 is high.
- busy  output  1  high in any state other than IDLE.
- mem_enable, mem_rw  output  1 each  to memory Enable, ReadWrite.
- mem_address, mem_data_in  output  32 each  to memory.
- mem_size  output  2  to memory Size.
- mem_data_out  input  32  from memory DataOut.

Behaviour:
- Reset, synchronous and active-high: FSM to IDLE; all outputs 0; latched request cleared; wait counter 0; last_grant = 1.
- Reset overrides all other events. Reset during ACCESS drops mem_enable at that edge, and memory contents of an interrupted write are unspecified.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner (see arbitration).
  - Latch the winner's rw/addr/wdata/size and record it as last_grant.
  - Evaluate fault. If fault, go to RESP with err=1; otherwise go to ACCESS with counter=0.
  - If no req, stay in IDLE.
- Fault conditions:
  - size == 11.
  - half with addr[0] != 0.
  - word with addr[1:0] != 0.
  - addr + nbytes - 1 >= MEM_BYTES, where nbytes is 1, 2 or 4; compute in 33 bits so there is no wrap-around.
  - A faulting access never asserts mem_enable.
- ACCESS:
  - mem_enable = 1, with mem_rw/mem_address/mem_data_in/mem_size driven from the latch and stable for the whole window.
  - Counter increments each cycle.
  - When counter == ACCESS_CYCLES-1: if read, register mem_data_out masked to size (byte [7:0], half [15:0], upper bits 0); then go to RESP.
- RESP:
  - mem_enable = 0.
  - ack of the granted port = 1 for exactly one cycle, with rsp_data (0 for writes and faults) and rsp_err.
  - Then go to IDLE.
- Latency:
  - Legal access: req sampled in IDLE at edge N, ack high in cycle N+ACCESS_CYCLES+1.
  - Fault: ack high in cycle N+1.
  - Minimum back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- Handshake:
  - A requester drops req in the cycle after it sees ack. If req is still high in IDLE, it is a new request.
  - Changes to a requester's fields while it is granted are ignored.
  - rsp_data/rsp_err are held unchanged until the next RESP.
- mem_* outputs other than mem_enable hold their last values outside ACCESS.
- Arbitration:
  - Fixed priority: port 0 wins when both requesters are pending.
  - A single pending requester always wins.

Optional Feature:
- RR_ARB_EN defined: round-robin arbitration. With both req high in IDLE, the port that is not last_grant wins, so after reset port 0 wins first. A single requester is still granted immediately.
- RR_ARB_EN undefined: fixed priority, port 0 always wins. last_grant is still tracked but unused.

Test Plan:
- Word write then read: port 0 writes addr=0x10, wdata=0xDEADBEEF, size=10; then reads it with ACCESS_CYCLES=1 -> mem_enable high exactly 1 cycle per access; write ack0 at N+2 with rsp_data=0; read ack0 with rsp_data=0xDEADBEEF, rsp_err=0.
- Sub-word reads: byte read at 0x11 -> rsp_data=0x000000AD; half read at 0x12 -> rsp_data=0x0000BEEF.
- Faults: half at 0x13, word at 0x0E, word at 0xFE, size=11 -> each gives ack at N+1 with rsp_err=1, mem_enable never asserted, memory unchanged.
- Contention: req0 and req1 high together and held. Without RR_ARB_EN -> ack0 first, then port 0 again on re-request. With RR_ARB_EN -> grants alternate 0,1,0,1.
- Reset mid-access: ACCESS_CYCLES=4, assert reset in the 2nd ACCESS cycle -> next cycle all outputs 0 and busy=0, no ack issued; a new request completes normally afterwards.
- Write data check: port 1 writes byte 0x5A at addr 0xFF -> legal, ack1 with err=0; a subsequent byte read of 0xFF returns 0x0000005A.
